// File: rtl/flow_light_ctrl.sv
// Flowing-light controller: prescaled position counter with hold/left/right/bounce
// modes driving a one-hot LED vector. Define FLOW_LIGHT_TRAIL_EN for a 2-LED comet trail.
//
// state   | meaning
// ST_UP   | bounce moving toward LEDS-1 (also left-shift direction)
// ST_DOWN | bounce moving toward 0 (also right-shift direction)
module flow_light_ctrl #(
    parameter int LEDS     = 8,
    parameter int DIV      = 25000000,
    parameter int DIV_BITS = 25,
    parameter int POS_BITS = 3
) (
    input  logic                clk,
    input  logic                r,
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic                load,
    input  logic [POS_BITS-1:0] load_pos,
    output logic [POS_BITS-1:0] pos,
    output logic [LEDS-1:0]     led,
    output logic                tick,
    output logic                wrap
);

    typedef enum logic {
        ST_UP   = 1'b0,
        ST_DOWN = 1'b1
    } dir_e;

    localparam logic [DIV_BITS-1:0]  PRESC_LAST = DIV_BITS'(DIV - 1);
    localparam logic [DIV_BITS-1:0]  PRESC_ONE  = DIV_BITS'(1);
    localparam logic [POS_BITS-1:0]  POS_LAST   = POS_BITS'(LEDS - 1);
    localparam logic [POS_BITS-1:0]  POS_ONE    = POS_BITS'(1);
    localparam logic [POS_BITS:0]    LEDS_EXT   = (POS_BITS + 1)'(LEDS);
    localparam logic [LEDS-1:0]      LED_BIT0   = LEDS'(1);

    logic [DIV_BITS-1:0] presc_q, presc_d;
    logic [POS_BITS-1:0] pos_q, pos_d;
    dir_e                dir_q, dir_d;

    logic presc_end;
    logic at_top;
    logic at_bot;
    logic boundary;

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            presc_q <= '0;
            pos_q   <= '0;
            dir_q   <= ST_UP;
        end else begin
            presc_q <= presc_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
        end
    end

    // Tick is gated by reset so the strobes stay low while r is held, even for DIV=1.
    always_comb begin
        presc_end = (presc_q == PRESC_LAST);
        at_top    = (pos_q == POS_LAST);
        at_bot    = (pos_q == '0);
        tick      = en & ~r & presc_end;
        boundary  = 1'b0;
        case (mode)
            2'b01:   boundary = at_top;
            2'b10:   boundary = at_bot;
            2'b11:   boundary = (dir_q == ST_UP) ? at_top : at_bot;
            default: boundary = 1'b0;
        endcase
        wrap = tick & boundary;
    end

    always_comb begin
        presc_d = presc_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        if (load) begin
            pos_d   = ({1'b0, load_pos} >= LEDS_EXT) ? POS_LAST : load_pos;
            presc_d = '0;
            dir_d   = ST_UP;
        end else begin
            if (en) begin
                presc_d = presc_end ? '0 : presc_q + PRESC_ONE;
            end
            if (tick) begin
                case (mode)
                    2'b01: begin
                        pos_d = at_top ? '0 : pos_q + POS_ONE;
                        dir_d = ST_UP;
                    end
                    2'b10: begin
                        pos_d = at_bot ? POS_LAST : pos_q - POS_ONE;
                        dir_d = ST_DOWN;
                    end
                    2'b11: begin
                        if (dir_q == ST_UP) begin
                            if (at_top) begin
                                pos_d = POS_LAST - POS_ONE;
                                dir_d = ST_DOWN;
                            end else begin
                                pos_d = pos_q + POS_ONE;
                            end
                        end else begin
                            if (at_bot) begin
                                pos_d = POS_ONE;
                                dir_d = ST_UP;
                            end else begin
                                pos_d = pos_q - POS_ONE;
                            end
                        end
                    end
                    default: pos_d = pos_q;
                endcase
            end
        end
    end

    assign pos = pos_q;

`ifdef FLOW_LIGHT_TRAIL_EN
    logic [POS_BITS-1:0] trail_q, trail_d;
    logic                step;

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            trail_q <= '0;
        end else begin
            trail_q <= trail_d;
        end
    end

    // Trail remembers where the head was before each move or load.
    always_comb begin
        step    = load | (tick & (mode != 2'b00));
        trail_d = step ? pos_q : trail_q;
        led     = (LED_BIT0 << pos_q) | (LED_BIT0 << trail_q);
    end
`else
    always_comb begin
        led = LED_BIT0 << pos_q;
    end
`endif

endmodule
